mult_dot_host: RTL and testbench
================================

# mult_dot_host

Host-side controller for the multiplier's operand/result interface. It accepts a job of N operand pairs, streams the pairs into the multiplier through the `EN_mult`/`RDY_mult` handshake, and waits for the products to drain into product memory. It then issues `EN_blockRead`, collects the `VALID_memVal`/`memVal_data` result stream, and returns the accumulated dot product with a completion pulse. It sits between a job source (CPU register block or test sequencer) and the multiplier.

## Interface
- `DEPTH`, 64: maximum pairs per job; equals multiplier product-memory depth.
- `DRAIN_CYC`, 4: idle cycles between the last accepted pair and `EN_blockRead`; covers multiplier pipeline plus memory write.
- `TIMEOUT`, 1024: maximum cycles in COLLECT without a `VALID_memVal`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  job start pulse; sampled only in IDLE.
- `len`  in  7  pair count for the job, sampled with `start`; legal range 1..DEPTH.
- `op_valid`  in  1  operand pair available.
- `op_ready`  out  1  pair accepted when `op_valid && op_ready`.
- `op_a`, `op_b`  in  16 each  operand pair, unsigned.
- `EN_mult`  out  1  drive pair to multiplier.
- `mult_input0`, `mult_input1`  out  16 each  operands to multiplier.
- `RDY_mult`  in  1  multiplier can accept a pair this cycle.
- `EN_blockRead`  out  1  one-cycle request for the multiplier to stream stored products.
- `VALID_memVal`  in  1  `memVal_data` valid this cycle.
- `memVal_data`  in  32  product, unsigned, returned in write order.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle job-complete pulse.
- `dot_sum`  out  48  accumulated sum of products.
- `res_count`  out  7  results received in the current or last job.
- `err_len`  out  1  one-cycle pulse when `start` arrives with an illegal `len`.
- `err_timeout`  out  1  sticky until next accepted `start`; COLLECT timed out.

## Operation
- States: IDLE, FEED, DRAIN, REQ, COLLECT, DONE.
- IDLE: `start` with 1 ≤ `len` ≤ DEPTH latches `len`, clears `dot_sum`, `res_count`, the sent counter and `err_timeout`, then goes to FEED. An illegal `len` pulses `err_len` and stays in IDLE. `start` in any other state is ignored.
- FEED: `op_ready` = `RDY_mult`; `EN_mult` = `op_valid`; `mult_input0`/`mult_input1` = `op_a`/`op_b` (combinational pass-through). A transfer occurs when `op_valid && RDY_mult`, and each transfer increments the sent count. When the transfer makes sent == len, go to DRAIN. Outside FEED, `op_ready` and `EN_mult` are 0 and the mult inputs are 0.
- DRAIN: count DRAIN_CYC cycles, then go to REQ.
- REQ: `EN_blockRead` = 1 for exactly this one cycle, then go to COLLECT.
- COLLECT: each `VALID_memVal` adds zero-extended `memVal_data` to `dot_sum` and increments `res_count`. When `res_count` reaches len, go to DONE. If TIMEOUT consecutive cycles pass with no VALID, set `err_timeout` and go to DONE. The idle counter resets on every VALID.
- DONE: `done` = 1 for one cycle, then go to IDLE. `dot_sum` and `res_count` hold until the next accepted `start`.
- `VALID_memVal` outside COLLECT is ignored. Results beyond len are ignored.
- Width: 64 × (2^32−1) < 2^38, so the 48-bit sum cannot overflow. No saturation logic.

## Timing
- Reset (`rst` low, async): state IDLE. All outputs are 0: `op_ready`, `EN_mult`, `mult_input0/1`, `EN_blockRead`, `busy`, `done`, `dot_sum`, `res_count`, `err_len`, `err_timeout`.
- Reset mid-job aborts immediately. No `done` is produced, and the job restarts only on a new `start`.
- `start` at edge k puts the block in FEED and raises `busy` from cycle k+1.
- A pair accepted at edge j that is the last pair puts the block in DRAIN at j+1. `EN_blockRead` is high during cycle j+1+DRAIN_CYC.
- A VALID at edge m is reflected in `dot_sum` and `res_count` at m+1. The final VALID at edge m gives `done` high in cycle m+1 with the final `dot_sum`, and IDLE at m+2.
- `RDY_mult` low stalls FEED indefinitely with no timeout. `op_valid` may deassert freely.
- `err_len` is high in the cycle after the offending `start` edge.

## Test plan
- Nominal: `len`=9, pairs (1,9),(2,8)…(9,1), `RDY_mult` always 1, model returns products -> exactly 9 `EN_mult` transfers, one `EN_blockRead` pulse, `done` with `dot_sum`=165 and `res_count`=9.
- Backpressure: same job with `RDY_mult` toggling 1/0 and `op_valid` gapped -> no pair lost or duplicated, `dot_sum`=165, `EN_blockRead` exactly DRAIN_CYC+1 cycles after the last transfer.
- Bounds: `len`=0 and `len`=65 -> `err_len` pulse, `busy` stays 0. `len`=64 with all pairs (65535,65535) -> `dot_sum`=64×4294836225=274869518400.
- Timeout: `len`=4, model returns only 3 results -> after TIMEOUT idle cycles, `err_timeout`=1, `done` pulse, `res_count`=3.
- Spurious/extra: VALID pulses in IDLE and FEED, 5 results for `len`=4, and `start` during COLLECT -> all ignored, `dot_sum` counts only the first 4.
- Reset mid-COLLECT: assert `rst`=0 after 2 of 5 results -> all outputs 0 asynchronously, no `done`. A new job with `len`=2, pairs (3,4),(5,6) -> `dot_sum`=42.

Source files
------------

// File: rtl/mult_dot_host.sv
// mult_dot_host: feeds operand pairs into the multiplier, reads back the stored
// products and accumulates them into a dot product.
module mult_dot_host #(
    parameter int DEPTH     = 64,
    parameter int DRAIN_CYC = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  len,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        EN_mult,
    output logic [15:0] mult_input0,
    output logic [15:0] mult_input1,
    input  logic        RDY_mult,
    output logic        EN_blockRead,
    input  logic        VALID_memVal,
    input  logic [31:0] memVal_data,
    output logic        busy,
    output logic        done,
    output logic [47:0] dot_sum,
    output logic [6:0]  res_count,
    output logic        err_len,
    output logic        err_timeout
);
    localparam int DW = $clog2(DRAIN_CYC + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, FEED, DRAIN, REQ, COLLECT, DONE} stateT;

    stateT         state;
    logic [6:0]    jobLen;
    logic [6:0]    sentCnt;
    logic [DW-1:0] drainCnt;
    logic [TW-1:0] idleCnt;
    logic          feeding;

    // Operand path is a pure pass-through while feeding, forced quiet otherwise.
    assign feeding      = state == FEED;
    assign op_ready     = feeding && RDY_mult;
    assign EN_mult      = feeding && op_valid;
    assign mult_input0  = feeding ? op_a : '0;
    assign mult_input1  = feeding ? op_b : '0;
    assign EN_blockRead = state == REQ;
    assign busy         = state != IDLE;
    assign done         = state == DONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            jobLen      <= '0;
            sentCnt     <= '0;
            drainCnt    <= '0;
            idleCnt     <= '0;
            dot_sum     <= '0;
            res_count   <= '0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            err_len <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (len != 7'd0 && len <= 7'(DEPTH)) begin
                        jobLen      <= len;
                        sentCnt     <= '0;
                        dot_sum     <= '0;
                        res_count   <= '0;
                        err_timeout <= 1'b0;
                        state       <= FEED;
                    end else begin
                        err_len <= 1'b1;
                    end
                end
                FEED: if (op_valid && RDY_mult) begin
                    sentCnt <= sentCnt + 7'd1;
                    if (sentCnt + 7'd1 == jobLen) begin
                        drainCnt <= '0;
                        state    <= DRAIN;
                    end
                end
                DRAIN: if (drainCnt == DW'(DRAIN_CYC - 1)) state <= REQ;
                       else drainCnt <= drainCnt + 1'b1;
                REQ: begin
                    idleCnt <= '0;
                    state   <= COLLECT;
                end
                // Idle counter restarts on every result; only a continuous silence times out.
                COLLECT: if (VALID_memVal) begin
                    dot_sum   <= dot_sum + 48'(memVal_data);
                    res_count <= res_count + 7'd1;
                    idleCnt   <= '0;
                    if (res_count + 7'd1 == jobLen) state <= DONE;
                end else if (idleCnt == TW'(TIMEOUT - 1)) begin
                    err_timeout <= 1'b1;
                    state       <= DONE;
                end else begin
                    idleCnt <= idleCnt + 1'b1;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_dot_host.sv
// tb_mult_dot_host: random and directed jobs against a behavioural multiplier;
// expected dot products are queued at issue time and matched on each done pulse.
module tb_mult_dot_host;
    localparam int DEPTH = 64, DRAIN_CYC = 4, TIMEOUT = 1024;

    logic        clk = 0, rst = 0, start = 0, op_valid = 0, RDY_mult = 0, VALID_memVal = 0;
    logic [6:0]  len = '0;
    logic [15:0] op_a = '0, op_b = '0;
    logic [31:0] memVal_data = '0;
    logic        op_ready, EN_mult, EN_blockRead, busy, done, err_len, err_timeout;
    logic [15:0] mult_input0, mult_input1;
    logic [47:0] dot_sum;
    logic [6:0]  res_count;

    always #5 clk = ~clk;

    mult_dot_host #(.DEPTH(DEPTH), .DRAIN_CYC(DRAIN_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .EN_mult(EN_mult), .mult_input0(mult_input0), .mult_input1(mult_input1),
        .RDY_mult(RDY_mult), .EN_blockRead(EN_blockRead),
        .VALID_memVal(VALID_memVal), .memVal_data(memVal_data),
        .busy(busy), .done(done), .dot_sum(dot_sum), .res_count(res_count),
        .err_len(err_len), .err_timeout(err_timeout)
    );

    typedef struct {
        longint unsigned sum;
        int              cnt;
        bit              tout;
    } expT;

    expT         sb[$];
    int          checks = 0, errors = 0;
    int          cyc = 0;
    int          rdyMode = 0, retLimit = -1, extra = 0;
    bit          spurious = 0, gapped = 0;
    int          xfers = 0, reads = 0, lastXfer = 0;
    logic [31:0] prodQ[$], sendQ[$];
    logic [15:0] aQ[$], bQ[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding job.
    always @(negedge clk) begin : mon
        expT e;
        if (rst && done) begin
            chk("done_expected", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("dot_sum", 64'(dot_sum), e.sum);
                chk("res_count", 64'(res_count), 64'(e.cnt));
                chk("err_timeout", 64'(err_timeout), 64'(e.tout));
            end
        end
    end

    // Behavioural multiplier: stores products of accepted pairs, streams them on request.
    initial begin : multModel
        int toSend;
        toSend = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prodQ.delete();
                sendQ.delete();
                toSend = 0;
            end else begin
                if (EN_mult && op_ready) begin
                    prodQ.push_back(32'(mult_input0) * 32'(mult_input1));
                    xfers++;
                    lastXfer = cyc;
                end
                if (EN_blockRead) begin
                    reads++;
                    chk("blockread_latency", 64'(cyc - lastXfer), 64'(DRAIN_CYC + 1));
                    sendQ = prodQ;
                    prodQ.delete();
                    toSend = retLimit >= 0 ? retLimit : sendQ.size() + extra;
                end
            end
            @(posedge clk); #1;
            RDY_mult = rdyMode == 0 ? 1'b1 : rdyMode == 1 ? ~RDY_mult : 1'($urandom_range(0, 1));
            if (!rst) begin
                VALID_memVal = 1'b0;
            end else if (toSend > 0 && $urandom_range(0, 3) != 0) begin
                VALID_memVal = 1'b1;
                memVal_data = sendQ.size() > 0 ? sendQ.pop_front() : $urandom;
                toSend--;
            end else if (spurious && toSend == 0) begin
                VALID_memVal = 1'($urandom_range(0, 1));
                memVal_data = $urandom;
            end else begin
                VALID_memVal = 1'b0;
            end
        end
    end

    task automatic fillRand(input int n);
        aQ.delete();
        bQ.delete();
        repeat (n) begin
            aQ.push_back(16'($urandom));
            bQ.push_back(16'($urandom));
        end
    endtask

    task automatic checkZero(input string tag);
        chk({tag, "_ctl"}, 64'({op_ready, EN_mult, mult_input0, mult_input1, EN_blockRead,
                                busy, done, err_len, err_timeout}), 64'd0);
        chk({tag, "_dot_sum"}, 64'(dot_sum), 64'd0);
        chk({tag, "_res_count"}, 64'(res_count), 64'd0);
    endtask

    task automatic badLen(input int n);
        @(posedge clk); #1;
        start = 1'b1;
        len = 7'(n);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("err_len_pulse", 64'(err_len), 64'd1);
        chk("busy_bad_len", 64'(busy), 64'd0);
        @(negedge clk);
        chk("err_len_clear", 64'(err_len), 64'd0);
        chk("busy_bad_len2", 64'(busy), 64'd0);
    endtask

    // ret < 0: all products returned; poke: start pulse during COLLECT; abortAt >= 0: reset after that many results.
    task automatic runJob(input int n, input int ret, input bit poke, input int abortAt);
        expT e;
        int  got, i, budget;
        got = ret < 0 ? n : (ret < n ? ret : n);
        e.sum = 0;
        for (int k = 0; k < got; k++) e.sum += longint'(aQ[k]) * longint'(bQ[k]);
        e.cnt = got;
        e.tout = ret >= 0 && ret < n;
        retLimit = ret;
        xfers = 0;
        reads = 0;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b1;
        len = 7'(n);
        @(posedge clk); #1;
        start = 1'b0;
        i = 0;
        budget = 0;
        while (i < n && budget < 5000) begin
            op_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
            op_a = aQ[i];
            op_b = bQ[i];
            @(negedge clk);
            if (op_valid && op_ready) i++;
            @(posedge clk); #1;
            budget++;
        end
        op_valid = 1'b0;
        chk("feed_complete", 64'(i), 64'(n));
        if (poke) begin
            budget = 0;
            while (reads == 0 && budget < 100) begin
                @(negedge clk);
                budget++;
            end
            @(posedge clk); #1;
            start = 1'b1;
            len = 7'd3;
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (abortAt >= 0) begin
            budget = 0;
            do begin
                @(negedge clk);
                budget++;
            end while (res_count < 7'(abortAt) && budget < 2000);
            chk("abort_point", 64'(res_count), 64'(abortAt));
            #2 rst = 1'b0;
            sb.delete();
            #1 checkZero("abort");
            repeat (3) @(posedge clk);
            #1 rst = 1'b1;
            return;
        end
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (busy && budget < 3000);
        chk("job_finished", 64'(busy), 64'd0);
        chk("mult_transfers", 64'(xfers), 64'(n));
        chk("blockread_pulses", 64'(reads), 64'd1);
    endtask

    initial begin
        rst = 1'b0;
        #3 checkZero("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        aQ.delete();
        bQ.delete();
        for (int k = 1; k <= 9; k++) begin
            aQ.push_back(16'(k));
            bQ.push_back(16'(10 - k));
        end
        runJob(9, -1, 0, -1);
        chk("nominal_sum", 64'(dot_sum), 64'd165);

        gapped = 1;
        rdyMode = 1;
        runJob(9, -1, 0, -1);
        chk("backpressure_sum", 64'(dot_sum), 64'd165);
        gapped = 0;
        rdyMode = 0;

        badLen(0);
        badLen(65);

        aQ.delete();
        bQ.delete();
        repeat (64) begin
            aQ.push_back(16'hFFFF);
            bQ.push_back(16'hFFFF);
        end
        runJob(64, -1, 0, -1);
        chk("max_sum", 64'(dot_sum), 64'd274869518400);

        fillRand(4);
        runJob(4, 3, 0, -1);
        chk("timeout_sticky", 64'(err_timeout), 64'd1);

        spurious = 1;
        extra = 1;
        repeat (4) @(posedge clk);
        fillRand(4);
        runJob(4, -1, 1, -1);
        repeat (4) @(posedge clk);
        chk("spurious_idle_busy", 64'(busy), 64'd0);
        spurious = 0;
        extra = 0;

        fillRand(5);
        runJob(5, -1, 0, 2);
        repeat (2) @(negedge clk);
        chk("after_abort_idle", 64'(busy), 64'd0);

        aQ.delete();
        bQ.delete();
        aQ.push_back(16'd3);
        bQ.push_back(16'd4);
        aQ.push_back(16'd5);
        bQ.push_back(16'd6);
        runJob(2, -1, 0, -1);
        chk("post_reset_sum", 64'(dot_sum), 64'd42);

        rdyMode = 2;
        gapped = 1;
        repeat (6) begin
            int n;
            n = $urandom_range(1, DEPTH);
            fillRand(n);
            runJob(n, -1, 0, -1);
        end

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
